sum_request_scheduler: RTL and testbench
========================================

Name: sum_request_scheduler

Overview:
- Upstream feeder for the sum-of-naturals Datapath (N in, 18-bit Sum out).
- Buffers N requests from a producer in a small FIFO and issues them to the Datapath one at a time.
- Waits for each Sum, with a timeout, then returns {N, Sum} to a consumer over a valid/ready handshake.
- Serialises traffic so the Datapath never sees a new N while busy.

Parameters:
- FIFO_DEPTH, 4, request FIFO entries; power of 2, ≥2.
- TIMEOUT_CYCLES, 1024, max cycles in WAIT before abandoning a request; ≥2.

Ports:
- Clk  input  1  single clock, rising edge.
- Rst  input  1  synchronous, active-high reset.
- req_n  input  8  requested N.
- req_valid  input  1  producer has a request.
- req_ready  output  1  FIFO not full; request accepted when req_valid && req_ready at a rising edge.
- dp_n  output  8  N driven to the Datapath; stable from ISSUE through WAIT.
- dp_n_valid  output  1  one-cycle start pulse to the Datapath.
- dp_sum  input  18  Datapath result.
- dp_sum_valid  input  1  Datapath result-valid pulse.
- rsp_n  output  8  N of the returned result.
- rsp_sum  output  18  returned Sum; 0 on timeout.
- rsp_timeout  output  1  result abandoned by timeout.
- rsp_valid  output  1  response available.
- rsp_ready  input  1  consumer accepts.
- pending  output  $clog2(FIFO_DEPTH)+1  FIFO occupancy.

Behaviour:
- Reset: FIFO emptied; state=IDLE; all outputs 0; req_ready=1 in the first cycle after reset. Rst mid-operation drops all queued and in-flight requests. No response is emitted for them. Datapath shares Rst.
- FIFO: push on req_valid && req_ready. Pop only on the IDLE->ISSUE transition. No pass-through. When full, req_ready=0 and a simultaneous pop does not free the slot until the next cycle. Pointers wrap modulo FIFO_DEPTH. pending updates the cycle after push/pop; push and pop in the same edge leave it unchanged.
- FSM states: IDLE, ISSUE, WAIT, HOLD.
- IDLE: when FIFO is non-empty, pop the head into dp_n register and go to ISSUE.
- ISSUE: dp_n_valid=1 for exactly this cycle; go to WAIT; clear timer.
- WAIT:
  - dp_sum_valid=1: capture rsp_sum=dp_sum, rsp_n=dp_n, rsp_timeout=0; go to HOLD.
  - Else, timer reaches TIMEOUT_CYCLES-1: rsp_sum=0, rsp_n=dp_n, rsp_timeout=1; go to HOLD.
  - dp_sum_valid in the same cycle as expiry: the valid result wins.
  - Otherwise timer increments.
- HOLD: rsp_valid=1, response fields stable until rsp_ready; on rsp_valid && rsp_ready go to IDLE. rsp_valid deasserts the next cycle.
- Latency: a request accepted at edge e into an empty FIFO in IDLE produces dp_n_valid in the cycle after edge e+1. Response appears the cycle after the dp_sum_valid edge. One IDLE bubble between consecutive requests.
- dp_sum_valid outside WAIT is ignored.
- Widths: N 8-bit unsigned; max valid sum 32640 fits 18 bits; no truncation.

Optional Feature:
- Macro: SUM_CHECK_EN.
- Defined:
  - Adds output rsp_mismatch (1 bit), registered with the response.
  - rsp_mismatch=1 when a non-timeout result has dp_sum != N*(N+1)/2. Closed form computed as 17-bit from dp_n.
  - rsp_mismatch=0 on timeout; 0 at reset.
- Undefined: port and logic absent; everything else identical.

Decomposition:
- Package sum_sched_pkg:
  - State enum {IDLE, ISSUE, WAIT, HOLD}.
  - N_W=8, SUM_W=18.
  - Function expected_sum(n) (used under SUM_CHECK_EN).
- Sub-module sum_req_fifo: parametrised synchronous FIFO with push/pop/full/empty/count. Instantiated once.

Test Plan:
- Single request: reset, push N=5; Datapath model returns 15 after 6 cycles -> one dp_n_valid pulse with dp_n=5; rsp_valid with rsp_n=5, rsp_sum=15, rsp_timeout=0.
- Backpressure/full: FIFO_DEPTH=4, push N=1,2,3,4,5,6 back-to-back with rsp_ready=0 -> req_ready falls after 4 pending plus 1 in flight. Responses released in order 1,3,6,10,15,21 once rsp_ready=1. No duplicate or skipped dp_n_valid.
- Timeout: TIMEOUT_CYCLES=8, Datapath model never answers N=9 -> after 8 WAIT cycles rsp_valid, rsp_n=9, rsp_sum=0, rsp_timeout=1. Next queued request issues normally.
- Race: dp_sum_valid on the expiry cycle with Sum=45, N=9 -> rsp_sum=45, rsp_timeout=0.
- Reset mid-operation: Rst=1 during WAIT with 2 pending -> next cycle pending=0, rsp_valid=0, dp_n_valid=0, state IDLE. A late dp_sum_valid after reset is ignored.
- SUM_CHECK_EN: model returns 16 for N=5 -> rsp_mismatch=1; returns 32640 for N=255 -> rsp_mismatch=0.

Source files
------------

// File: rtl/sum_sched_pkg.sv
// Shared types and constants for the sum request scheduler.
// The expected_sum helper is only used when SUM_CHECK_EN is defined.
package sum_sched_pkg;

    localparam int N_W   = 8;
    localparam int SUM_W = 18;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        HOLD  = 2'd3
    } sched_state_e;

    // Closed-form sum of naturals 1..n, 17 bits wide (255*256/2 = 32640).
    function automatic logic [16:0] expected_sum(input logic [N_W-1:0] n);
        logic [16:0] prod;
        prod = {9'd0, n} * ({9'd0, n} + 17'd1);
        return {1'b0, prod[16:1]};
    endfunction

endpackage

// File: rtl/sum_req_fifo.sv
// Synchronous request FIFO. Full/empty come from the registered count, so a
// pop in the same cycle as a full condition frees the slot only next cycle.
module sum_req_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 8
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       push_i,
    input  logic [W-1:0]               din_i,
    input  logic                       pop_i,
    output logic [W-1:0]               dout_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH):0]     count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;
    logic          push_s;
    logic          pop_s;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign push_s  = push_i && !full_o;
    assign pop_s   = pop_i && !empty_o;
    assign dout_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

    // Occupancy next-state: simultaneous push and pop leave it unchanged.
    always_comb begin
        count_d = count_q;
        case ({push_s, pop_s})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Storage array; contents need no reset since reads are gated by empty.
    always_ff @(posedge clk_i) begin
        if (push_s) begin
            mem_q[wr_ptr_q] <= din_i;
        end
    end

    // Pointers and occupancy; pointers wrap naturally as DEPTH is a power of 2.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_s) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop_s) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/sum_request_scheduler.sv
// Feeds N requests one at a time to the sum-of-naturals datapath, waits for
// the result (with timeout) and returns {N, Sum} to a consumer.
// Optional feature macro: SUM_CHECK_EN adds rsp_mismatch, flagging results
// that disagree with the closed form n*(n+1)/2.
module sum_request_scheduler
    import sum_sched_pkg::*;
#(
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                          Clk,
    input  logic                          Rst,
    input  logic [N_W-1:0]                req_n,
    input  logic                          req_valid,
    output logic                          req_ready,
    output logic [N_W-1:0]                dp_n,
    output logic                          dp_n_valid,
    input  logic [SUM_W-1:0]              dp_sum,
    input  logic                          dp_sum_valid,
    output logic [N_W-1:0]                rsp_n,
    output logic [SUM_W-1:0]              rsp_sum,
    output logic                          rsp_timeout,
    output logic                          rsp_valid,
    input  logic                          rsp_ready,
    output logic [$clog2(FIFO_DEPTH):0]   pending
`ifdef SUM_CHECK_EN
    ,
    output logic                          rsp_mismatch
`endif
);

    localparam int TW = $clog2(TIMEOUT_CYCLES);
    localparam logic [TW-1:0] TMR_LAST = TW'(TIMEOUT_CYCLES - 1);

    sched_state_e   state_q;
    logic [N_W-1:0] dp_n_q;
    logic           dp_n_valid_q;
    logic [TW-1:0]  timer_q;
    logic [N_W-1:0] rsp_n_q;
    logic [SUM_W-1:0] rsp_sum_q;
    logic           rsp_timeout_q;
    logic           rsp_valid_q;
`ifdef SUM_CHECK_EN
    logic           rsp_mismatch_q;
`endif

    logic [N_W-1:0] fifo_dout_s;
    logic           fifo_full_s;
    logic           fifo_empty_s;
    logic           pop_s;

    // The head is taken only on the IDLE->ISSUE step; no pass-through.
    assign pop_s     = (state_q == IDLE) && !fifo_empty_s;
    assign req_ready = !fifo_full_s;

    sum_req_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (N_W)
    ) u_fifo (
        .clk_i   (Clk),
        .rst_i   (Rst),
        .push_i  (req_valid),
        .din_i   (req_n),
        .pop_i   (pop_s),
        .dout_o  (fifo_dout_s),
        .full_o  (fifo_full_s),
        .empty_o (fifo_empty_s),
        .count_o (pending)
    );

    // Scheduler FSM with all datapath/consumer outputs registered.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q        <= IDLE;
            dp_n_q         <= '0;
            dp_n_valid_q   <= 1'b0;
            timer_q        <= '0;
            rsp_n_q        <= '0;
            rsp_sum_q      <= '0;
            rsp_timeout_q  <= 1'b0;
            rsp_valid_q    <= 1'b0;
`ifdef SUM_CHECK_EN
            rsp_mismatch_q <= 1'b0;
`endif
        end else begin
            dp_n_valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (!fifo_empty_s) begin
                        dp_n_q       <= fifo_dout_s;
                        dp_n_valid_q <= 1'b1;
                        state_q      <= ISSUE;
                    end
                end
                ISSUE: begin
                    timer_q <= '0;
                    state_q <= WAIT;
                end
                WAIT: begin
                    // A valid result on the expiry cycle takes priority.
                    if (dp_sum_valid) begin
                        rsp_n_q        <= dp_n_q;
                        rsp_sum_q      <= dp_sum;
                        rsp_timeout_q  <= 1'b0;
                        rsp_valid_q    <= 1'b1;
`ifdef SUM_CHECK_EN
                        rsp_mismatch_q <= (dp_sum != {1'b0, expected_sum(dp_n_q)});
`endif
                        state_q        <= HOLD;
                    end else if (timer_q == TMR_LAST) begin
                        rsp_n_q        <= dp_n_q;
                        rsp_sum_q      <= '0;
                        rsp_timeout_q  <= 1'b1;
                        rsp_valid_q    <= 1'b1;
`ifdef SUM_CHECK_EN
                        rsp_mismatch_q <= 1'b0;
`endif
                        state_q        <= HOLD;
                    end else begin
                        timer_q <= timer_q + TW'(1);
                    end
                end
                HOLD: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign dp_n        = dp_n_q;
    assign dp_n_valid  = dp_n_valid_q;
    assign rsp_n       = rsp_n_q;
    assign rsp_sum     = rsp_sum_q;
    assign rsp_timeout = rsp_timeout_q;
    assign rsp_valid   = rsp_valid_q;
`ifdef SUM_CHECK_EN
    assign rsp_mismatch = rsp_mismatch_q;
`endif

endmodule

// File: tb/tb_sum_request_scheduler.sv
// Self-checking bench for sum_request_scheduler (FIFO_DEPTH=4, TIMEOUT_CYCLES=8).
// A datapath model answers each start pulse after a planned delay; expected
// responses come from the request order plus the delay plan.
`timescale 1ns/1ps
module tb_sum_request_scheduler;

    localparam int DEPTH = 4;
    localparam int TMO   = 8;

    logic        Clk = 1'b0;
    logic        Rst;
    logic [7:0]  req_n;
    logic        req_valid;
    logic        req_ready;
    logic [7:0]  dp_n;
    logic        dp_n_valid;
    logic [17:0] dp_sum;
    logic        dp_sum_valid;
    logic [7:0]  rsp_n;
    logic [17:0] rsp_sum;
    logic        rsp_timeout;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [2:0]  pending;
`ifdef SUM_CHECK_EN
    logic        rsp_mismatch;
`endif

    always #5 Clk = ~Clk;

    sum_request_scheduler #(.FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(TMO)) dut (
        .Clk(Clk), .Rst(Rst), .req_n(req_n), .req_valid(req_valid), .req_ready(req_ready),
        .dp_n(dp_n), .dp_n_valid(dp_n_valid), .dp_sum(dp_sum), .dp_sum_valid(dp_sum_valid),
        .rsp_n(rsp_n), .rsp_sum(rsp_sum), .rsp_timeout(rsp_timeout), .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready), .pending(pending)
`ifdef SUM_CHECK_EN
        , .rsp_mismatch(rsp_mismatch)
`endif
    );

    typedef struct { int n; int sum; bit tmo; bit mm; int stamp; } rsp_t;

    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    int   rdy_mode = 1;
    bit   will_accept = 1'b0;
    int   req_q[$];
    int   plan_q[$];
    bit   corrupt_q[$];
    rsp_t exp_q[$];
    rsp_t obs_q[$];
    int   iss_q[$];
    int   iss_stamp_q[$];
    int   dm_d, dm_n;
    bit   dm_c;

    always @(posedge Clk) cyc <= cyc + 1;

    // Producer: present the head of req_q until accepted.
    initial begin
        req_valid = 1'b0;
        req_n     = 8'd0;
        forever begin
            @(negedge Clk);
            if (will_accept && req_q.size() > 0) void'(req_q.pop_front());
            if (Rst == 1'b0 && req_q.size() > 0) begin
                req_valid = 1'b1;
                req_n     = 8'(req_q[0]);
            end else begin
                req_valid = 1'b0;
            end
            will_accept = req_valid && req_ready;
        end
    end

    // Datapath model: answer after the planned delay (0 = never answer).
    initial begin
        dp_sum_valid = 1'b0;
        dp_sum       = 18'd0;
        forever begin
            @(negedge Clk);
            if (dp_n_valid && plan_q.size() > 0) begin
                dm_d = plan_q.pop_front();
                dm_c = corrupt_q.pop_front();
                dm_n = int'(dp_n);
                if (dm_d > 0) begin
                    repeat (dm_d) @(negedge Clk);
                    dp_sum       = 18'(dm_n * (dm_n + 1) / 2 + (dm_c ? 1 : 0));
                    dp_sum_valid = 1'b1;
                    @(negedge Clk);
                    dp_sum_valid = 1'b0;
                end
            end
        end
    end

    // Issue monitor.
    always @(negedge Clk) begin
        if (dp_n_valid) begin
            iss_q.push_back(int'(dp_n));
            iss_stamp_q.push_back(cyc);
        end
    end

    // Consumer: choose rsp_ready, record accepted responses.
    initial begin
        rsp_t r;
        rsp_ready = 1'b0;
        forever begin
            @(negedge Clk);
            case (rdy_mode)
                0:       rsp_ready = 1'b0;
                1:       rsp_ready = 1'b1;
                default: rsp_ready = ($urandom_range(0, 2) != 0);
            endcase
            if (rsp_valid && rsp_ready) begin
                r.n = int'(rsp_n); r.sum = int'(rsp_sum); r.tmo = rsp_timeout; r.stamp = cyc;
`ifdef SUM_CHECK_EN
                r.mm = rsp_mismatch;
`else
                r.mm = 1'b0;
`endif
                obs_q.push_back(r);
            end
        end
    end

    task automatic send(input int n, input int d, input bit c);
        rsp_t e;
        req_q.push_back(n); plan_q.push_back(d); corrupt_q.push_back(c);
        e.n = n;
        e.tmo = !(d >= 1 && d <= TMO);
        e.sum = e.tmo ? 0 : (n * (n + 1) / 2 + (c ? 1 : 0));
`ifdef SUM_CHECK_EN
        e.mm = !e.tmo && c;
`else
        e.mm = 1'b0;
`endif
        e.stamp = 0;
        exp_q.push_back(e);
    endtask

    task automatic wait_rsps(input int cnt, input int budget, output bit ok);
        int k = 0;
        while (obs_q.size() < cnt && k < budget) begin
            @(posedge Clk); #1; k++;
        end
        ok = (obs_q.size() >= cnt);
    endtask

    task automatic settle_and_clear();
        repeat (14) @(posedge Clk);
        #1;
        obs_q.delete(); exp_q.delete(); iss_q.delete(); iss_stamp_q.delete();
    endtask

    task automatic test_reset();
        Rst = 1'b1;
        repeat (2) @(posedge Clk);
        #1 Rst = 1'b0;
        @(posedge Clk); #1;
        total++;
        if (req_ready !== 1'b1 || pending !== 3'd0) begin
            bad++; $display("FAIL reset_fifo req_ready=%0b pending=%0d want 1/0", req_ready, pending);
        end
        total++;
        if ({rsp_valid, dp_n_valid, rsp_timeout, rsp_n, rsp_sum, dp_n} !== 37'd0) begin
            bad++; $display("FAIL reset_outs rsp_valid=%0b dp_n_valid=%0b tmo=%0b rsp_n=%0d rsp_sum=%0d dp_n=%0d want all 0",
                            rsp_valid, dp_n_valid, rsp_timeout, rsp_n, rsp_sum, dp_n);
        end
    endtask

    task automatic test_single();
        bit ok; rsp_t o;
        rdy_mode = 1;
        send(5, 6, 1'b0);
        wait_rsps(1, 200, ok);
        total++;
        if (!ok) begin bad++; $display("FAIL single_wait got=%0d want=1 responses", obs_q.size()); end
        o = ok ? obs_q[0] : '{n: -1, sum: -1, tmo: 1'b0, mm: 1'b0, stamp: 0};
        total++;
        if (o.n !== 5 || o.sum !== 15 || o.tmo !== 1'b0) begin
            bad++; $display("FAIL single_rsp got n=%0d sum=%0d tmo=%0b want 5/15/0", o.n, o.sum, o.tmo);
        end
        total++;
        if (iss_q.size() !== 1 || (iss_q.size() > 0 && iss_q[0] !== 5)) begin
            bad++; $display("FAIL single_issue got count=%0d want one pulse with dp_n=5", iss_q.size());
        end
        total++;
        if (ok && iss_q.size() > 0 && (o.stamp - iss_stamp_q[0]) !== 7) begin
            bad++; $display("FAIL single_latency got=%0d want=7 cycles", o.stamp - iss_stamp_q[0]);
        end
        settle_and_clear();
    endtask

    task automatic test_backpressure();
        bit ok; rsp_t o;
        rdy_mode = 0;
        for (int i = 1; i <= 6; i++) send(i, 3, 1'b0);
        repeat (14) @(posedge Clk);
        #1;
        total++;
        if (req_ready !== 1'b0 || pending !== 3'd4 || iss_q.size() !== 1) begin
            bad++; $display("FAIL full req_ready=%0b pending=%0d issued=%0d want 0/4/1", req_ready, pending, iss_q.size());
        end
        rdy_mode = 1;
        wait_rsps(6, 300, ok);
        for (int i = 0; i < 6; i++) begin
            o = (i < obs_q.size()) ? obs_q[i] : '{n: -1, sum: -1, tmo: 1'b0, mm: 1'b0, stamp: 0};
            total++;
            if (o.n !== exp_q[i].n || o.sum !== exp_q[i].sum || o.tmo !== exp_q[i].tmo) begin
                bad++; $display("FAIL bp_rsp[%0d] got n=%0d sum=%0d tmo=%0b want %0d/%0d/%0b",
                                i, o.n, o.sum, o.tmo, exp_q[i].n, exp_q[i].sum, exp_q[i].tmo);
            end
        end
        total++;
        if (iss_q.size() !== 6) begin
            bad++; $display("FAIL bp_issue_count got=%0d want=6", iss_q.size());
        end else begin
            for (int i = 0; i < 6; i++) begin
                total++;
                if (iss_q[i] !== i + 1) begin
                    bad++; $display("FAIL bp_issue[%0d] got=%0d want=%0d", i, iss_q[i], i + 1);
                end
            end
        end
        settle_and_clear();
    endtask

    task automatic test_timeout_and_race();
        bit ok; rsp_t o;
        rdy_mode = 1;
        send(9, 0, 1'b0);     // never answered
        send(4, 3, 1'b0);     // next request must issue normally
        send(9, TMO, 1'b0);   // answer lands on the expiry cycle
        wait_rsps(3, 400, ok);
        for (int i = 0; i < 3; i++) begin
            o = (i < obs_q.size()) ? obs_q[i] : '{n: -1, sum: -1, tmo: 1'b0, mm: 1'b0, stamp: 0};
            total++;
            if (o.n !== exp_q[i].n || o.sum !== exp_q[i].sum || o.tmo !== exp_q[i].tmo) begin
                bad++; $display("FAIL tmo_rsp[%0d] got n=%0d sum=%0d tmo=%0b want %0d/%0d/%0b",
                                i, o.n, o.sum, o.tmo, exp_q[i].n, exp_q[i].sum, exp_q[i].tmo);
            end
        end
        total++;
        if (ok && iss_stamp_q.size() >= 3 &&
            ((obs_q[0].stamp - iss_stamp_q[0]) !== TMO + 1 || (obs_q[2].stamp - iss_stamp_q[2]) !== TMO + 1)) begin
            bad++; $display("FAIL tmo_latency got=%0d,%0d want=%0d cycles",
                            obs_q[0].stamp - iss_stamp_q[0], obs_q[2].stamp - iss_stamp_q[2], TMO + 1);
        end
        settle_and_clear();
    endtask

    task automatic test_reset_mid();
        int k = 0;
        rdy_mode = 1;
        send(7, 6, 1'b0); send(2, 3, 1'b0); send(3, 3, 1'b0);
        while (iss_q.size() < 1 && k < 50) begin @(posedge Clk); #1; k++; end
        repeat (2) @(posedge Clk);
        #1;
        total++;
        if (pending !== 3'd2 || iss_q.size() !== 1) begin
            bad++; $display("FAIL mid_pre pending=%0d issued=%0d want 2/1", pending, iss_q.size());
        end
        Rst = 1'b1;
        req_q.delete(); plan_q.delete(); corrupt_q.delete(); exp_q.delete();
        will_accept = 1'b0; req_valid = 1'b0;
        @(posedge Clk); #1 Rst = 1'b0;
        total++;
        if (pending !== 3'd0 || rsp_valid !== 1'b0 || dp_n_valid !== 1'b0 || req_ready !== 1'b1) begin
            bad++; $display("FAIL mid_reset pending=%0d rsp_valid=%0b dp_n_valid=%0b req_ready=%0b want 0/0/0/1",
                            pending, rsp_valid, dp_n_valid, req_ready);
        end
        repeat (16) @(posedge Clk);
        #1;
        total++;
        if (obs_q.size() !== 0 || iss_q.size() !== 1 || rsp_valid !== 1'b0) begin
            bad++; $display("FAIL mid_late rsps=%0d issued=%0d rsp_valid=%0b want 0/1/0",
                            obs_q.size(), iss_q.size(), rsp_valid);
        end
        settle_and_clear();
    endtask

    task automatic test_sum_check();
        bit ok; rsp_t o;
        rdy_mode = 1;
        send(5, 4, 1'b1);     // wrong sum 16
        send(255, 4, 1'b0);   // 32640, correct
        wait_rsps(2, 200, ok);
        for (int i = 0; i < 2; i++) begin
            o = (i < obs_q.size()) ? obs_q[i] : '{n: -1, sum: -1, tmo: 1'b0, mm: 1'b0, stamp: 0};
            total++;
            if (o.n !== exp_q[i].n || o.sum !== exp_q[i].sum || o.tmo !== exp_q[i].tmo || o.mm !== exp_q[i].mm) begin
                bad++; $display("FAIL sumchk[%0d] got n=%0d sum=%0d tmo=%0b mm=%0b want %0d/%0d/%0b/%0b",
                                i, o.n, o.sum, o.tmo, o.mm, exp_q[i].n, exp_q[i].sum, exp_q[i].tmo, exp_q[i].mm);
            end
        end
        settle_and_clear();
    endtask

    task automatic test_random();
        bit ok; rsp_t o; int cnt; int d;
        rdy_mode = 2;
        cnt = 24;
        for (int i = 0; i < cnt; i++) begin
            d = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 9));
            send(int'($urandom_range(0, 255)), d, ($urandom_range(0, 3) == 0));
        end
        wait_rsps(cnt, 3000, ok);
        total++;
        if (!ok) begin bad++; $display("FAIL rand_wait got=%0d want=%0d responses", obs_q.size(), cnt); end
        for (int i = 0; i < cnt; i++) begin
            o = (i < obs_q.size()) ? obs_q[i] : '{n: -1, sum: -1, tmo: 1'b0, mm: 1'b0, stamp: 0};
            total++;
            if (o.n !== exp_q[i].n || o.sum !== exp_q[i].sum || o.tmo !== exp_q[i].tmo || o.mm !== exp_q[i].mm) begin
                bad++; $display("FAIL rand_rsp[%0d] got n=%0d sum=%0d tmo=%0b mm=%0b want %0d/%0d/%0b/%0b",
                                i, o.n, o.sum, o.tmo, o.mm, exp_q[i].n, exp_q[i].sum, exp_q[i].tmo, exp_q[i].mm);
            end
        end
        total++;
        if (iss_q.size() !== cnt) begin
            bad++; $display("FAIL rand_issue_count got=%0d want=%0d", iss_q.size(), cnt);
        end
        settle_and_clear();
    endtask

    initial begin
        test_reset();
        test_single();
        test_backpressure();
        test_timeout_and_race();
        test_reset_mid();
        test_sum_check();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
